// File: rtl/button_debounce.sv
// Push-button debouncer with press/release/long-press pulse generation.
//
// The raw pin is normalised so that 1 means pressed, passed through a
// two-flop synchroniser, and then filtered by a four-state FSM that only
// accepts a level change after DEBOUNCE_CYCLES consecutive stable samples.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   btn_in       raw asynchronous push-button pin
//   btn_level    debounced pressed level (1 = pressed)
//   btn_press    one-cycle pulse on an accepted press
//   btn_release  one-cycle pulse on an accepted release
//   btn_long     one-cycle pulse once a press has been held LONG_CYCLES
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  // Counters are wide enough to hold their terminal value without wrapping.
  localparam int unsigned DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = (LONG_CYCLES < 1) ? 1 : $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam bit            LONG_EN  = (LONG_CYCLES != 0);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t        state;
  logic          btn_meta;
  logic          btn_sync;
  logic [DW-1:0] stable_cnt;
  logic [HW-1:0] hold_cnt;

  logic btn_norm;
  logic hold_inc;
  logic hold_hit;

  // Normalise polarity so the rest of the logic always sees pressed = 1.
  assign btn_norm = ACTIVE_LOW ? ~btn_in : btn_in;

  // Hold counter advances until it saturates; the step that reaches the
  // limit is the only one that can raise btn_long for a given press.
  assign hold_inc = LONG_EN && (hold_cnt != HOLD_MAX);
  assign hold_hit = hold_inc && (hold_cnt == (HOLD_MAX - HW'(1)));

  // Synchroniser, debounce FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RELEASED;
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      stable_cnt  <= '0;
      hold_cnt    <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      btn_meta    <= btn_norm;
      btn_sync    <= btn_meta;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;

      case (state)
        RELEASED: begin
          btn_level <= 1'b0;
          if (btn_sync) begin
            state      <= WAIT_PRESS;
            stable_cnt <= DW'(1);
          end else begin
            stable_cnt <= '0;
          end
        end

        WAIT_PRESS: begin
          if (!btn_sync) begin
            state      <= RELEASED;
            stable_cnt <= '0;
          end else if (stable_cnt == DB_MAX) begin
            state      <= PRESSED;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            btn_level  <= 1'b1;
            btn_press  <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + DW'(1);
          end
        end

        PRESSED: begin
          if (hold_inc) hold_cnt <= hold_cnt + HW'(1);
          btn_long <= hold_hit;
          if (!btn_sync) begin
            state      <= WAIT_RELEASE;
            stable_cnt <= DW'(1);
          end else begin
            stable_cnt <= '0;
          end
        end

        WAIT_RELEASE: begin
          if (hold_inc) hold_cnt <= hold_cnt + HW'(1);
          if (btn_sync) begin
            // Bounce back to pressed: no new press pulse, hold time preserved.
            state      <= PRESSED;
            stable_cnt <= '0;
            btn_long   <= hold_hit;
          end else if (stable_cnt == DB_MAX) begin
            // Release wins over a coincident long-press so pulses never overlap.
            state       <= RELEASED;
            stable_cnt  <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + DW'(1);
            btn_long   <= hold_hit;
          end
        end

        default: begin
          state      <= RELEASED;
          stable_cnt <= '0;
          btn_level  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed testbench for button_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// active-low pin). Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, so every tick is one sampling edge.
module tb_button_debounce;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  int errors;
  int checks;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 1'b1;
    tick();
    tick();
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {btn_level, btn_press, btn_release, btn_long});
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press} !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle k=%0d: got %b expected 00", k, {btn_level, btn_press});
      end
    end
  endtask

  // Pin goes low and stays low; press pulse appears on the 6th edge after the first low sample.
  task automatic do_press(input string name);
    btn_in = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (btn_press !== (k == 6) || btn_level !== (k == 6) || btn_release !== 1'b0) begin
        errors++;
        $display("FAIL %s_press k=%0d: got press=%b level=%b release=%b expected press=%b level=%b release=0",
                 name, k, btn_press, btn_level, btn_release, k == 6, k == 6);
      end
    end
  endtask

  // Pin goes high and stays high; release pulse appears on the 6th edge.
  task automatic do_release(input string name);
    btn_in = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (btn_release !== (k == 6) || btn_level !== (k != 6) ||
          btn_press !== 1'b0 || btn_long !== 1'b0) begin
        errors++;
        $display("FAIL %s_release k=%0d: got release=%b level=%b press=%b long=%b expected release=%b level=%b press=0 long=0",
                 name, k, btn_release, btn_level, btn_press, btn_long, k == 6, k != 6);
      end
    end
  endtask

  task automatic test_clean_press();
    do_press("clean");
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== 4'b1000) begin
        errors++;
        $display("FAIL clean_hold k=%0d: got %b expected 1000", k,
                 {btn_level, btn_press, btn_release, btn_long});
      end
    end
    do_release("clean");
  endtask

  // Four low samples is one short of the minimum, so nothing is accepted.
  task automatic test_short_pulse();
    btn_in = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    btn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press} !== 2'b00) begin
        errors++;
        $display("FAIL short_pulse k=%0d: got level/press %b expected 00", k, {btn_level, btn_press});
      end
    end
  endtask

  task automatic test_bounce();
    btn_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press} !== 2'b00) begin
        errors++;
        $display("FAIL bounce_low k=%0d: got %b expected 00", k, {btn_level, btn_press});
      end
    end
    btn_in = 1'b1;
    tick();
    checks++;
    if ({btn_level, btn_press} !== 2'b00) begin
      errors++;
      $display("FAIL bounce_high: got %b expected 00", {btn_level, btn_press});
    end
    do_press("bounce");
  endtask

  // Continues from the press left by test_bounce: long pulse exactly 20 edges later, once.
  task automatic test_long_press();
    int longs;
    longs = 0;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (btn_long === 1'b1) longs++;
      checks++;
      if (btn_long !== (j == 20) || btn_press !== 1'b0 || btn_release !== 1'b0 || btn_level !== 1'b1) begin
        errors++;
        $display("FAIL long_hold j=%0d: got long=%b press=%b release=%b level=%b expected long=%b press=0 release=0 level=1",
                 j, btn_long, btn_press, btn_release, btn_level, j == 20);
      end
    end
    checks++;
    if (longs !== 1) begin
      errors++;
      $display("FAIL long_count: got %0d expected 1", longs);
    end
    do_release("long");
  endtask

  task automatic test_release_glitch();
    do_press("glitch");
    btn_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) btn_in = 1'b0;
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release, btn_long} !== 4'b1000) begin
        errors++;
        $display("FAIL glitch_hold k=%0d: got %b expected 1000", k,
                 {btn_level, btn_press, btn_release, btn_long});
      end
    end
    do_release("glitch");
  endtask

  task automatic test_reset_mid_press();
    do_press("midrst");
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_outputs: got %b expected 0000",
               {btn_level, btn_press, btn_release, btn_long});
    end
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (btn_press !== (k == 6) || btn_level !== (k == 6) || btn_release !== 1'b0) begin
        errors++;
        $display("FAIL midrst_repress k=%0d: got press=%b level=%b release=%b expected press=%b level=%b release=0",
                 k, btn_press, btn_level, btn_release, k == 6, k == 6);
      end
    end
    do_release("midrst");
  endtask

  task automatic test_back_to_back();
    do_press("b2b_first");
    do_release("b2b_first");
    do_press("b2b_second");
    do_release("b2b_second");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    btn_in = 1'b1;
    test_reset();
    test_clean_press();
    test_short_pulse();
    test_bounce();
    test_long_press();
    test_release_glitch();
    test_reset_mid_press();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
